// File: rtl/dac_controller_if.sv
// dac_controller_if: FIFO read handshake (fifo_empty, fifo_read_enable, fifo_read_data) between the DAC controller (master) and its source FIFO (slave)
interface dac_controller_if;
  logic        fifo_empty;
  logic        fifo_read_enable;
  logic [11:0] fifo_read_data;
  modport master (input fifo_empty, fifo_read_data, output fifo_read_enable);
  modport slave (output fifo_empty, fifo_read_data, input fifo_read_enable);
endinterface

// File: rtl/dac_controller.sv
// dac_controller: pops 12-bit FIFO words and shifts {00,pd_mode,word} MSB-first to a serial DAC (clk,reset,fifo if,pd_mode,gap_counts -> sclk,sync_n,din,dac_write_done,underrun,dac_state); define DAC_UNDERRUN_EN for the sticky underrun flag
module dac_controller (
  input  logic             clk,
  input  logic             reset,
  dac_controller_if.master fifo,
  input  logic [1:0]       pd_mode,
  input  logic [7:0]       gap_counts,
  output logic             dac_write_done,
  output logic             sclk,
  output logic             sync_n,
  output logic             din,
  output logic             underrun,
  output logic [2:0]       dac_state
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, SHIFT = 3'd2, GAP = 3'd3} state_t;
  state_t      state_q, state_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  cnt_q, cnt_d, gap_q, gap_d;
  logic        rd_en_q, rd_en_d, done_q, done_d, sclk_q, sclk_d, sync_n_q, sync_n_d, din_q, din_d;
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  state_d = rd_en_q ? LOAD : IDLE;
      LOAD: begin
        state_d = SHIFT;
        frame_d = {2'b00, pd_mode, fifo.fifo_read_data};
        cnt_d   = '0;
      end
      SHIFT: begin
        state_d = (cnt_q == 8'd31) ? GAP : SHIFT;
        done_d  = cnt_q == 8'd31;
        cnt_d   = (cnt_q == 8'd31) ? 8'd0 : cnt_q + 8'd1;
        gap_d   = (cnt_q != 8'd31) ? gap_q : (gap_counts == 8'd0) ? 8'd1 : gap_counts;
      end
      GAP: begin
        state_d = (gap_q <= 8'd1) ? IDLE : GAP;
        gap_d   = (gap_q <= 8'd1) ? 8'd0 : gap_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    rd_en_d  = (state_d == IDLE) && !fifo.fifo_empty;
    sync_n_d = state_d != SHIFT;
    sclk_d   = (state_d != SHIFT) || !cnt_d[0];
    din_d    = (state_d == SHIFT) && frame_d[~cnt_d[4:1]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      rd_en_q  <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      din_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      rd_en_q  <= rd_en_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      din_q    <= din_d;
    end
  end
`ifdef DAC_UNDERRUN_EN
  logic seen_q, seen_d, underrun_q, underrun_d;
  always_comb begin
    seen_d     = seen_q | done_d;
    underrun_d = underrun_q | (state_q == GAP && state_d == IDLE && fifo.fifo_empty && seen_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      seen_q     <= seen_d;
      underrun_q <= underrun_d;
    end
  end
  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif
  assign fifo.fifo_read_enable = rd_en_q;
  assign dac_write_done        = done_q;
  assign sclk                  = sclk_q;
  assign sync_n                = sync_n_q;
  assign din                   = din_q;
  assign dac_state             = state_q;
endmodule

// File: tb/tb_dac_controller.sv
// tb_dac_controller: table-driven and scoreboard bench for dac_controller
module tb_dac_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] pd_mode = 2'b00;
  logic [7:0] gap_counts = 8'd0;
  logic       dac_write_done, sclk, sync_n, din, underrun;
  logic [2:0] dac_state;
`ifdef DAC_UNDERRUN_EN
  localparam logic UR = 1'b1;
`else
  localparam logic UR = 1'b0;
`endif
  dac_controller_if fifo_if ();
  dac_controller dut (
    .clk(clk), .reset(reset), .fifo(fifo_if), .pd_mode(pd_mode), .gap_counts(gap_counts),
    .dac_write_done(dac_write_done), .sclk(sclk), .sync_n(sync_n), .din(din),
    .underrun(underrun), .dac_state(dac_state)
  );
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  logic [11:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_if.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk)
    if (fifo_if.fifo_read_enable === 1'b1) begin
      fifo_if.fifo_read_data <= mem[rd_ptr[5:0]];
      rd_ptr <= rd_ptr + 1;
    end
  logic [15:0] exp_q[$];
  task automatic push(input logic [11:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask
  logic        prev_sync = 1'b1;
  logic        prev_sclk = 1'b1;
  logic [15:0] sh = '0;
  int nbits = 0, low = 0, last_low = 0, rd_cnt = 0, n_fall = 0, n_rise = 0;
  int fall_t[64];
  int rise_t[64];
  always @(negedge clk) begin
    if (sync_n === 1'b0 && prev_sync === 1'b1) begin
      if (n_fall < 64) fall_t[n_fall] = cyc;
      n_fall++;
      nbits = 0;
      low = 0;
    end
    if (sync_n === 1'b1 && prev_sync === 1'b0) begin
      if (n_rise < 64) rise_t[n_rise] = cyc;
      n_rise++;
      last_low = low;
    end
    if (sync_n === 1'b0) low++;
    if (sync_n === 1'b0 && prev_sclk === 1'b1 && sclk === 1'b0) begin
      sh = {sh[14:0], din};
      nbits++;
    end
    if (fifo_if.fifo_read_enable === 1'b1) begin
      rd_cnt++;
      chk("rd_en_while_empty", fifo_if.fifo_empty, 0);
    end
    if (sync_n === 1'b1) chk("din_idle", din, 0);
    if (dac_write_done === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        chk("frame_bits", nbits, 16);
        chk("frame", sh, exp_q.pop_front());
      end
    end
    prev_sync = sync_n;
    prev_sclk = sclk;
  end
  typedef struct {
    logic [11:0] word;
    logic [1:0]  pd;
    logic [7:0]  gap;
    logic [15:0] frame;
  } vec_t;
  vec_t vecs[6];
  task automatic run_vec(input vec_t v);
    int t, g, rd0;
    pd_mode = v.pd;
    gap_counts = v.gap;
    rd0 = rd_cnt;
    push(v.word);
    exp_q.push_back(v.frame);
    t = 0;
    while (dac_write_done !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
      if (sync_n === 1'b0) pd_mode = v.pd ^ 2'b10;
    end
    chk("done_timeout", t < 300, 1);
    g = 0;
    while (dac_state == 3'd3 && g < 300) begin
      g++;
      gap_counts = 8'hFF;
      @(negedge clk);
    end
    chk("gap_len", g, (v.gap == 8'd0) ? 1 : v.gap);
    chk("rd_pulses", rd_cnt - rd0, 1);
    chk("sync_low_len", last_low, 32);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, dac_state, 0);
    chk({tag, "_sclk"}, sclk, 1);
    chk({tag, "_sync_n"}, sync_n, 1);
    chk({tag, "_din"}, din, 0);
    chk({tag, "_rd_en"}, fifo_if.fifo_read_enable, 0);
    chk({tag, "_done"}, dac_write_done, 0);
    chk({tag, "_underrun"}, underrun, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, k, nf0, nr0;
    vecs[0] = '{12'hA5C, 2'b00, 8'd4,  16'h0A5C};
    vecs[1] = '{12'hFFF, 2'b11, 8'd0,  16'h3FFF};
    vecs[2] = '{12'h001, 2'b01, 8'd1,  16'h1001};
    vecs[3] = '{12'h800, 2'b10, 8'd2,  16'h2800};
    vecs[4] = '{12'h5A5, 2'b11, 8'd7,  16'h35A5};
    vecs[5] = '{12'h3C3, 2'b00, 8'd12, 16'h03C3};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("post_rst");
    foreach (vecs[i]) run_vec(vecs[i]);
    chk("underrun_single", underrun, UR);
    pd_mode = 2'b00;
    gap_counts = 8'd4;
    nf0 = n_fall;
    nr0 = n_rise;
    push(12'h123); exp_q.push_back(16'h0123);
    push(12'h456); exp_q.push_back(16'h0456);
    push(12'h789); exp_q.push_back(16'h0789);
    k = 0;
    t = 0;
    while (k < 3 && t < 600) begin
      @(negedge clk);
      t++;
      if (dac_write_done === 1'b1) k++;
    end
    chk("b2b_frames", k, 3);
    repeat (10) @(negedge clk);
    chk("b2b_period_1_2", fall_t[nf0 + 1] - fall_t[nf0], 38);
    chk("b2b_period_2_3", fall_t[nf0 + 2] - fall_t[nf0 + 1], 38);
    chk("b2b_sync_high", fall_t[nf0 + 1] - rise_t[nr0], 6);
    chk("b2b_sync_high2", fall_t[nf0 + 2] - rise_t[nr0 + 1], 6);
    chk("underrun_drain", underrun, UR);
    push(12'h6B2);
    t = 0;
    while (sync_n !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("abort_start", t < 100, 1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("abort");
    reset = 1'b0;
    k = 0;
    repeat (60) begin
      @(negedge clk);
      if (dac_write_done === 1'b1) k++;
    end
    chk("abort_no_done", k, 0);
    chk("abort_underrun", underrun, 0);
    run_vec(vecs[4]);
    chk("underrun_again", underrun, UR);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dac_controller.md
DAC_CONTROLLER -- requirements
Module: dac_controller

Interface
REQ-001 SHALL have port clk  input  1  system clock (40 MHz).
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port fifo_empty  input  1  high when the source FIFO holds no word.
REQ-004 SHALL have port fifo_read_enable  output  1  one-cycle pop strobe to the FIFO.
REQ-005 SHALL have port fifo_read_data  input  12  FIFO word, valid on the cycle after fifo_read_enable.
REQ-006 SHALL have port pd_mode  input  2  DAC power-down bits PD1:PD0, sampled at LOAD.
REQ-007 SHALL have port gap_counts  input  8  minimum sync_n-high cycles between frames.
REQ-008 SHALL have port dac_write_done  output  1  one-cycle pulse per completed frame.
REQ-009 SHALL have port sclk  output  1  DAC serial clock.
REQ-010 SHALL have port sync_n  output  1  DAC frame sync, active low.
REQ-011 SHALL have port din  output  1  DAC serial data, MSB first.
REQ-012 SHALL have port underrun  output  1  sticky underrun flag (see Configuration).
REQ-013 SHALL have port dac_state  output  3  test point carrying the current state encoding.

Function
REQ-014 SHALL register every output; no output is driven combinationally.
REQ-015 SHALL implement the states IDLE=0, LOAD=1, SHIFT=2, GAP=3, with dac_state equal to the current state.
REQ-016 IDLE: if fifo_empty=0, SHALL assert fifo_read_enable for exactly one cycle and go to LOAD; otherwise SHALL stay in IDLE.
REQ-017 SHALL never assert fifo_read_enable while fifo_empty=1 or outside IDLE.
REQ-018 LOAD (one cycle): SHALL capture the 16-bit frame {2'b00, pd_mode, fifo_read_data}, then go to SHIFT.
REQ-019 SHALL hold sync_n low for all of SHIFT and only in SHIFT.
REQ-020 SHIFT SHALL last exactly 32 clk cycles as 16 bit-pairs (sclk = clk/2 = 20 MHz).
REQ-021 For bit-pair n (0..15): cycle A drives sclk=1 with din=frame[15-n]; cycle B drives sclk=0 with din held (the DAC samples on this falling edge).
REQ-022 After pair 15 cycle B, SHALL drive sync_n=1 and sclk=1, pulse dac_write_done for one cycle, and go to GAP.
REQ-023 GAP SHALL hold sync_n=1 and sclk=1 for max(gap_counts,1) cycles, then go to IDLE.
REQ-024 Back-to-back throughput SHALL be 1 (IDLE) + 1 (LOAD) + 32 (SHIFT) + max(gap_counts,1) (GAP) cycles per word.
REQ-025 SHALL ignore changes to pd_mode and gap_counts outside the cycle in which each is sampled (LOAD and GAP entry respectively).
REQ-026 Outside SHIFT, din SHALL be 0.
REQ-027 The bit counter and gap timer SHALL be 8 bits wide and SHALL NOT wrap within a frame.

Reset
REQ-028 On reset, SHALL set state=IDLE, sclk=1, sync_n=1, din=0, fifo_read_enable=0, dac_write_done=0, underrun=0, and clear all counters.
REQ-029 Reset asserted mid-SHIFT SHALL abort the frame at the next edge (sync_n=1) without a dac_write_done pulse; the popped word is discarded.

Configuration
REQ-030 With DAC_UNDERRUN_EN defined, underrun SHALL set when GAP exits to IDLE with fifo_empty=1 while at least one frame has completed since reset, and SHALL clear only on reset.
REQ-031 Without DAC_UNDERRUN_EN, underrun SHALL be tied to 0 and the related logic SHALL be omitted.

Verification
REQ-032 Reset, then one word 12'hA5C with pd_mode=2'b00 -> fifo_read_enable for 1 cycle; 16 falling sclk edges sample 0000_1010_0101_1100; dac_write_done pulses once.
REQ-033 Three queued words, gap_counts=4 -> each frame starts exactly 38 cycles after the previous one; sync_n is high for 4+2 cycles between frames.
REQ-034 gap_counts=0 -> GAP lasts exactly 1 cycle.
REQ-035 pd_mode=2'b11 at LOAD and changed to 2'b01 mid-SHIFT -> bits 13:12 sent as 11.
REQ-036 Reset at SHIFT cycle 10 -> next cycle sync_n=1, sclk=1, state=IDLE, no dac_write_done pulse.
REQ-037 With DAC_UNDERRUN_EN, one word then FIFO empty -> underrun=1 on GAP exit and stays set; without the macro, underrun stays 0.
